// File: rtl/banco_registradores_imm_pkg.sv
// Shared constants for the 64-bit RISC-V integer register file and its consumers:
// widths, opcodes and branch funct3 codes.
package banco_registradores_imm_pkg;

  localparam int XLEN     = 64;
  localparam int NREGS    = 32;
  localparam int REG_IDXW = 5;

  localparam logic [6:0] OP_LW      = 7'b0000011;
  localparam logic [6:0] OP_SW      = 7'b0100011;
  localparam logic [6:0] OP_ADD_SUB = 7'b0110011;
  localparam logic [6:0] OP_ADDI    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/banco_registradores_imm_imm_gen.sv
// Combinational I-type and B-type immediate extraction; the opcode is ignored,
// the consumer picks whichever immediate applies.
module imm_gen
  import banco_registradores_imm_pkg::*;
(
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imediato_I,
  output logic [XLEN-1:0] imediato_B
);

  // Opcode bits play no part in either immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  assign imediato_I = {{(XLEN-12){instr[31]}}, instr[31:20]};

  // B offset is always even: bit 0 is implicit zero.
  assign imediato_B = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                       instr[30:25], instr[11:8], 1'b0};

endmodule

// File: rtl/banco_registradores_imm.sv
// 32 x XLEN register file (x0 reads zero, 2 async reads, 1 sync write) plus immediates.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to the read ports.
module banco_registradores_imm
  import banco_registradores_imm_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_IDXW-1:0] Ra,
  input  logic [REG_IDXW-1:0] Rb,
  input  logic [REG_IDXW-1:0] Rw,
  input  logic                We,
  input  logic [XLEN-1:0]     din,
  output logic [XLEN-1:0]     douta,
  output logic [XLEN-1:0]     doutb,
  input  logic [31:0]         instr,
  output logic [XLEN-1:0]     imediato_I,
  output logic [XLEN-1:0]     imediato_B
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = We && !reset && (Rw != '0);

  // Entry 0 is cleared on reset and never written, but reads force zero anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[Rw] <= din;
    end
  end

  logic [XLEN-1:0] stored_a, stored_b;
  assign stored_a = (Ra == '0) ? '0 : regs_q[Ra];
  assign stored_b = (Rb == '0) ? '0 : regs_q[Rb];

`ifdef REGFILE_WRITE_BYPASS_EN
  assign douta = (wr_en && (Ra == Rw)) ? din : stored_a;
  assign doutb = (wr_en && (Rb == Rw)) ? din : stored_b;
`else
  assign douta = stored_a;
  assign doutb = stored_b;
`endif

  imm_gen u_imm_gen (
    .instr      (instr),
    .imediato_I (imediato_I),
    .imediato_B (imediato_B)
  );

endmodule

// File: tb/tb_banco_registradores_imm.sv
// Directed bench for banco_registradores_imm: immediate vector table plus
// hand-written register file sequences (reset, write, x0, reset priority).
module tb_banco_registradores_imm;
  import banco_registradores_imm_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [4:0]      Ra, Rb, Rw;
  logic            We;
  logic [XLEN-1:0] din;
  logic [XLEN-1:0] douta, doutb;
  logic [31:0]     instr;
  logic [XLEN-1:0] imediato_I, imediato_B;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  banco_registradores_imm dut (
    .clk        (clk),
    .reset      (reset),
    .Ra         (Ra),
    .Rb         (Rb),
    .Rw         (Rw),
    .We         (We),
    .din        (din),
    .douta      (douta),
    .doutb      (doutb),
    .instr      (instr),
    .imediato_I (imediato_I),
    .imediato_B (imediato_B)
  );

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] exp_i;
    logic [XLEN-1:0] exp_b;
  } imm_vec_t;

  imm_vec_t vecs [6];

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] pat(input int i);
    logic [31:0] idx;
    idx = 32'(i);
    return {idx * 32'h0101_0101, ~idx};
  endfunction

  logic [XLEN-1:0] exp_pre;

  initial begin
    vecs[0] = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE0};
    vecs[1] = '{32'h00A00093, 64'h0000_0000_0000_000A, 64'h0000_0000_0000_0800};
    vecs[2] = '{32'h00208463, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0008};
    vecs[3] = '{32'hFE208EE3, 64'hFFFF_FFFF_FFFF_FFE2, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[4] = '{32'h7E000FE3, 64'h0000_0000_0000_07E0, 64'h0000_0000_0000_0FFE};
    vecs[5] = '{32'h80000063, 64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_F000};

    reset = 1'b0; We = 1'b0; Ra = '0; Rb = '0; Rw = '0; din = '0; instr = '0;
    #2;

    for (int v = 0; v < 6; v++) begin
      instr = vecs[v].instr;
      #1;
      $display("imm vec %0d: instr=%h I=%h B=%h", v, instr, imediato_I, imediato_B);
      check($sformatf("imm_I[%0d]", v), imediato_I, vecs[v].exp_i);
      check($sformatf("imm_B[%0d]", v), imediato_B, vecs[v].exp_b);
    end

    // Garbage pre-load, then reset that also carries a write to x7.
    for (int i = 1; i < 32; i++) begin
      We = 1'b1; Rw = 5'(i); din = ~pat(i);
      tick();
    end
    reset = 1'b1; We = 1'b1; Rw = 5'd7; din = 64'h55;
    tick();
    reset = 1'b0; We = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i); Rb = 5'(i);
      #1;
      check($sformatf("reset_a[%0d]", i), douta, '0);
      check($sformatf("reset_b[%0d]", i), doutb, '0);
    end
    $display("reset sweep done");

    // Write x5, checking pre-edge value on the same index.
    We = 1'b1; Rw = 5'd5; din = 64'h0123_4567_89AB_CDEF; Ra = 5'd5; Rb = 5'd5;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_pre = 64'h0123_4567_89AB_CDEF;
`else
    exp_pre = '0;
`endif
    check("x5_pre_a", douta, exp_pre);
    check("x5_pre_b", doutb, exp_pre);
    tick();
    We = 1'b0;
    #1;
    $display("write x5: douta=%h doutb=%h", douta, doutb);
    check("x5_post_a", douta, 64'h0123_4567_89AB_CDEF);
    check("x5_post_b", doutb, 64'h0123_4567_89AB_CDEF);

    // We=0 must leave x5 untouched.
    Rw = 5'd5; din = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    check("we0_hold", douta, 64'h0123_4567_89AB_CDEF);

    // Writes to x0 are discarded and never bypassed.
    We = 1'b1; Rw = 5'd0; din = '1; Ra = 5'd0; Rb = 5'd0;
    #1;
    check("x0_pre", douta, '0);
    tick();
    We = 1'b0;
    #1;
    $display("write x0: douta=%h doutb=%h", douta, doutb);
    check("x0_post_a", douta, '0);
    check("x0_post_b", doutb, '0);

    // Reset mid-program beats a simultaneous write to x7.
    We = 1'b1; Rw = 5'd7; din = 64'hAA;
    tick();
    Ra = 5'd7;
    #1;
    check("x7_written", douta, 64'hAA);
    reset = 1'b1; We = 1'b1; Rw = 5'd7; din = 64'h55;
    #1;
    check("x7_during_reset", douta, 64'hAA);
    tick();
    reset = 1'b0; We = 1'b0;
    #1;
    $display("reset+write x7: douta=%h", douta);
    check("x7_reset_prio", douta, '0);

    // Fill every register with a distinct pattern and read back on both ports.
    for (int i = 1; i < 32; i++) begin
      We = 1'b1; Rw = 5'(i); din = pat(i);
      tick();
    end
    We = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Ra = 5'(i); Rb = 5'(31 - i);
      #1;
      check($sformatf("fill_a[%0d]", i), douta, (i == 0) ? '0 : pat(i));
      check($sformatf("fill_b[%0d]", 31 - i), doutb, (i == 31) ? '0 : pat(31 - i));
    end
    $display("fill sweep done");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
